// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Opcode/funct constants, ALU operation enum and register indices
//           shared by the decode and register-file stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_slti  = 6'h0A;
    localparam logic [5:0] c_op_andi  = 6'h0C;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lui   = 6'h0F;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_sll   = 6'h00;
    localparam logic [5:0] c_fn_srl   = 6'h02;
    localparam logic [5:0] c_fn_jr    = 6'h08;
    localparam logic [5:0] c_fn_add   = 6'h20;
    localparam logic [5:0] c_fn_sub   = 6'h22;
    localparam logic [5:0] c_fn_and   = 6'h24;
    localparam logic [5:0] c_fn_or    = 6'h25;
    localparam logic [5:0] c_fn_slt   = 6'h2A;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_e;

    function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        ok = 1'b0;
        case (op)
            c_op_rtype: begin
                case (fn)
                    c_fn_add, c_fn_sub, c_fn_and, c_fn_or,
                    c_fn_slt, c_fn_sll, c_fn_srl, c_fn_jr: ok = 1'b1;
                    default:                               ok = 1'b0;
                endcase
            end
            c_op_j, c_op_jal, c_op_beq, c_op_bne, c_op_addi, c_op_slti,
            c_op_andi, c_op_ori, c_op_lui, c_op_lw, c_op_sw: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_32x32.sv
// ============================================================================
// Module  : reg_file_32x32
// Purpose : 32x32 register file, two async reads, one sync write, async clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_32x32
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_SP = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    output logic [31:0] o_reg31
);

    logic [31:0] r_regs [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= (i == int'(REG_SP)) ? RESET_SP : 32'h0;
            end
        end else if (i_wr_en && (i_wr_addr != REG_ZERO)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Reads see the pre-edge contents; no write-through bypass.
    assign o_rs_data = (i_rs_addr == REG_ZERO) ? 32'h0 : r_regs[i_rs_addr];
    assign o_rt_data = (i_rt_addr == REG_ZERO) ? 32'h0 : r_regs[i_rt_addr];
    assign o_reg31   = r_regs[REG_RA];

endmodule

`default_nettype wire

// File: rtl/decode_regfile.sv
// ============================================================================
// Module  : decode_regfile
// Purpose : MIPS-subset instruction decode plus 32x32 register file.
//           Optional sticky illegal-instruction trap: DECODE_ILLEGAL_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_regfile
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_SP = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Inst,
    input  logic [31:0] Link_addr,
    input  logic [31:0] Wb_data,
    output logic [31:0] Rs_data,
    output logic [31:0] Rt_data,
    output logic [31:0] Imm_ext,
    output logic [4:0]  Shamt,
    output logic [3:0]  Alu_op,
    output logic        Alu_src,
    output logic        Mem_read,
    output logic        Mem_write,
    output logic        Mem_to_reg,
    output logic        Reg_write,
    output logic        Jump,
    output logic        Jump_reg,
    output logic        Branch_eq,
    output logic        Branch_ne,
    output logic [31:0] reg31,
    output logic        Illegal
);

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;

    alu_op_e     w_alu_op;
    logic        w_alu_src;
    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_mem_to_reg;
    logic        w_reg_write;
    logic        w_jump;
    logic        w_jump_reg;
    logic        w_branch_eq;
    logic        w_branch_ne;
    logic        w_zero_ext;
    logic        w_is_jal;
    logic [1:0]  w_dst_sel;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic        w_trap;

    localparam logic [1:0] c_dst_rt = 2'd0;
    localparam logic [1:0] c_dst_rd = 2'd1;
    localparam logic [1:0] c_dst_ra = 2'd2;

    assign w_opcode = Inst[31:26];
    assign w_rs     = Inst[25:21];
    assign w_rt     = Inst[20:16];
    assign w_rd     = Inst[15:11];
    assign w_imm    = Inst[15:0];
    assign w_funct  = Inst[5:0];

    always_comb begin
        w_alu_op     = ALU_ADD;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_jump       = 1'b0;
        w_jump_reg   = 1'b0;
        w_branch_eq  = 1'b0;
        w_branch_ne  = 1'b0;
        w_zero_ext   = 1'b0;
        w_is_jal     = 1'b0;
        w_dst_sel    = c_dst_rt;

        case (w_opcode)
            c_op_rtype: begin
                w_dst_sel = c_dst_rd;
                case (w_funct)
                    c_fn_add: begin w_alu_op = ALU_ADD; w_reg_write = 1'b1; end
                    c_fn_sub: begin w_alu_op = ALU_SUB; w_reg_write = 1'b1; end
                    c_fn_and: begin w_alu_op = ALU_AND; w_reg_write = 1'b1; end
                    c_fn_or:  begin w_alu_op = ALU_OR;  w_reg_write = 1'b1; end
                    c_fn_slt: begin w_alu_op = ALU_SLT; w_reg_write = 1'b1; end
                    c_fn_sll: begin w_alu_op = ALU_SLL; w_reg_write = 1'b1; end
                    c_fn_srl: begin w_alu_op = ALU_SRL; w_reg_write = 1'b1; end
                    c_fn_jr:  w_jump_reg = 1'b1;
                    default:  w_dst_sel  = c_dst_rt;
                endcase
            end
            c_op_j:   w_jump = 1'b1;
            c_op_jal: begin
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
                w_is_jal    = 1'b1;
                w_dst_sel   = c_dst_ra;
            end
            c_op_beq: begin w_branch_eq = 1'b1; w_alu_op = ALU_SUB; end
            c_op_bne: begin w_branch_ne = 1'b1; w_alu_op = ALU_SUB; end
            c_op_addi: begin
                w_alu_op = ALU_ADD; w_alu_src = 1'b1; w_reg_write = 1'b1;
            end
            c_op_slti: begin
                w_alu_op = ALU_SLT; w_alu_src = 1'b1; w_reg_write = 1'b1;
            end
            c_op_andi: begin
                w_alu_op = ALU_AND; w_alu_src = 1'b1; w_reg_write = 1'b1;
                w_zero_ext = 1'b1;
            end
            c_op_ori: begin
                w_alu_op = ALU_OR; w_alu_src = 1'b1; w_reg_write = 1'b1;
                w_zero_ext = 1'b1;
            end
            c_op_lui: begin
                w_alu_op = ALU_LUI; w_alu_src = 1'b1; w_reg_write = 1'b1;
            end
            c_op_lw: begin
                w_alu_op     = ALU_ADD;
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            c_op_sw: begin
                w_alu_op    = ALU_ADD;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky until reset; the offending instruction itself already decodes as a NOP.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_illegal <= 1'b0;
        end else if (!is_supported(w_opcode, w_funct)) begin
            r_illegal <= 1'b1;
        end
    end

    assign w_trap = r_illegal;
`else
    assign w_trap = 1'b0;
`endif

    assign w_wr_addr = (w_dst_sel == c_dst_ra) ? REG_RA :
                       (w_dst_sel == c_dst_rd) ? w_rd   : w_rt;
    assign w_wr_data = w_is_jal ? Link_addr : Wb_data;

    assign Imm_ext    = w_zero_ext ? {16'h0, w_imm} : {{16{w_imm[15]}}, w_imm};
    assign Shamt      = Inst[10:6];
    assign Alu_op     = w_alu_op;
    assign Alu_src    = w_alu_src;
    assign Mem_read   = w_mem_read;
    assign Mem_write  = w_mem_write;
    assign Mem_to_reg = w_mem_to_reg;
    assign Reg_write  = w_reg_write & ~w_trap;
    assign Jump       = w_jump      & ~w_trap;
    assign Jump_reg   = w_jump_reg  & ~w_trap;
    assign Branch_eq  = w_branch_eq & ~w_trap;
    assign Branch_ne  = w_branch_ne & ~w_trap;
    assign Illegal    = w_trap;

    reg_file_32x32 #(
        .RESET_SP (RESET_SP)
    ) u_reg_file (
        .clk       (Clock),
        .rst_n     (Reset),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .i_wr_en   (Reg_write),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .o_rs_data (Rs_data),
        .o_rt_data (Rt_data),
        .o_reg31   (reg31)
    );

endmodule

`default_nettype wire

// File: tb/tb_decode_regfile.sv
// ============================================================================
// Module  : tb_decode_regfile
// Purpose : Directed self-checking bench for decode_regfile.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_regfile;

    localparam logic [31:0] c_reset_sp = 32'h0000_1FF0;

    logic        Clock;
    logic        Reset;
    logic [31:0] Inst;
    logic [31:0] Link_addr;
    logic [31:0] Wb_data;
    logic [31:0] Rs_data;
    logic [31:0] Rt_data;
    logic [31:0] Imm_ext;
    logic [4:0]  Shamt;
    logic [3:0]  Alu_op;
    logic        Alu_src;
    logic        Mem_read;
    logic        Mem_write;
    logic        Mem_to_reg;
    logic        Reg_write;
    logic        Jump;
    logic        Jump_reg;
    logic        Branch_eq;
    logic        Branch_ne;
    logic [31:0] reg31;
    logic        Illegal;

    int n_checks = 0;
    int n_errors = 0;

    decode_regfile #(
        .RESET_SP (c_reset_sp)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Inst       (Inst),
        .Link_addr  (Link_addr),
        .Wb_data    (Wb_data),
        .Rs_data    (Rs_data),
        .Rt_data    (Rt_data),
        .Imm_ext    (Imm_ext),
        .Shamt      (Shamt),
        .Alu_op     (Alu_op),
        .Alu_src    (Alu_src),
        .Mem_read   (Mem_read),
        .Mem_write  (Mem_write),
        .Mem_to_reg (Mem_to_reg),
        .Reg_write  (Reg_write),
        .Jump       (Jump),
        .Jump_reg   (Jump_reg),
        .Branch_eq  (Branch_eq),
        .Branch_ne  (Branch_ne),
        .reg31      (reg31),
        .Illegal    (Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive just after a falling edge; the following rising edge commits.
    task automatic drive(input logic [31:0] inst, input logic [31:0] wb);
        @(negedge Clock);
        Inst    = inst;
        Wb_data = wb;
        #1;
    endtask

    initial begin
        Reset     = 1'b0;
        Inst      = 32'h1000_0000;
        Link_addr = 32'h0;
        Wb_data   = 32'h0;
        #1;
        check("rst_reg31", reg31, 32'h0);
        check("rst_illegal", {31'h0, Illegal}, 32'h0);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;

        // Read back every register through rs (beq never writes).
        for (int i = 0; i < 32; i++) begin
            logic [4:0] idx;
            idx = 5'(i);
            drive({6'h04, idx, 5'd0, 16'h0}, 32'hFFFF_FFFF);
            check($sformatf("rst_r%0d", i), Rs_data, (i == 29) ? c_reset_sp : 32'h0);
        end
        check("rst_reg31_after", reg31, 32'h0);

        // addi $1,$0,5
        drive(32'h2001_0005, 32'h5);
        check("addi_rw", {31'h0, Reg_write}, 32'h1);
        check("addi_src", {31'h0, Alu_src}, 32'h1);
        check("addi_op", {28'h0, Alu_op}, 32'h0);
        check("addi_imm", Imm_ext, 32'h5);
        drive(32'h1020_0000, 32'h0);
        check("addi_r1", Rs_data, 32'h5);

        // addi $0,$0,7 is discarded
        drive(32'h2000_0007, 32'h7);
        check("zero_rw", {31'h0, Reg_write}, 32'h1);
        drive(32'h1000_0000, 32'h0);
        check("zero_r0", Rs_data, 32'h0);

        // jal writes Link_addr into $31, visible only after the edge
        Link_addr = 32'h0000_0008;
        drive(32'h0C00_0010, 32'hDEAD_BEEF);
        check("jal_jump", {31'h0, Jump}, 32'h1);
        check("jal_rw", {31'h0, Reg_write}, 32'h1);
        check("jal_pre", reg31, 32'h0);
        drive(32'h101F_0000, 32'h0);
        check("jal_post", reg31, 32'h8);
        check("jal_rt31", Rt_data, 32'h8);

        // beq $1,$2,-4
        drive(32'h1022_FFFC, 32'h0);
        check("beq_br", {31'h0, Branch_eq}, 32'h1);
        check("beq_op", {28'h0, Alu_op}, 32'h1);
        check("beq_imm", Imm_ext, 32'hFFFF_FFFC);
        check("beq_rw", {31'h0, Reg_write}, 32'h0);
        check("beq_jump", {31'h0, Jump}, 32'h0);

        // ori $2,$1,0xFFFC
        drive(32'h3422_FFFC, 32'h0000_1234);
        check("ori_imm", Imm_ext, 32'h0000_FFFC);
        check("ori_op", {28'h0, Alu_op}, 32'h3);
        check("ori_rw", {31'h0, Reg_write}, 32'h1);
        drive(32'h1040_0000, 32'h0);
        check("ori_r2", Rs_data, 32'h0000_1234);

        // add $3,$1,$2
        drive(32'h0022_1820, 32'h0000_00AB);
        check("add_op", {28'h0, Alu_op}, 32'h0);
        check("add_src", {31'h0, Alu_src}, 32'h0);
        check("add_rw", {31'h0, Reg_write}, 32'h1);
        check("add_rs", Rs_data, 32'h5);
        check("add_rt", Rt_data, 32'h0000_1234);

        // addi $3,$3,1: same-cycle read returns the old value
        drive(32'h2063_0001, 32'h0000_0099);
        check("nobypass_old", Rs_data, 32'h0000_00AB);
        drive(32'h1060_0000, 32'h0);
        check("nobypass_new", Rs_data, 32'h0000_0099);

        // jr $31
        drive(32'h03E0_0008, 32'h0);
        check("jr_jreg", {31'h0, Jump_reg}, 32'h1);
        check("jr_jump", {31'h0, Jump}, 32'h0);
        check("jr_rw", {31'h0, Reg_write}, 32'h0);

        // lw $4,4($1)
        drive(32'h8C24_0004, 32'h0000_4444);
        check("lw_mr", {31'h0, Mem_read}, 32'h1);
        check("lw_m2r", {31'h0, Mem_to_reg}, 32'h1);
        check("lw_rw", {31'h0, Reg_write}, 32'h1);
        check("lw_src", {31'h0, Alu_src}, 32'h1);

        // sw $4,4($1)
        drive(32'hAC24_0004, 32'h0000_5555);
        check("sw_mw", {31'h0, Mem_write}, 32'h1);
        check("sw_rw", {31'h0, Reg_write}, 32'h0);
        check("sw_op", {28'h0, Alu_op}, 32'h0);
        drive(32'h1080_0000, 32'h0);
        check("lw_r4", Rs_data, 32'h0000_4444);

        // lui $5,0xABCD and bne
        drive(32'h3C05_ABCD, 32'h0);
        check("lui_op", {28'h0, Alu_op}, 32'h7);
        check("lui_imm", Imm_ext, 32'hFFFF_ABCD);
        drive(32'h1422_0003, 32'h0);
        check("bne_br", {31'h0, Branch_ne}, 32'h1);
        check("bne_op", {28'h0, Alu_op}, 32'h1);

        // sll $2,$3,2
        drive(32'h0003_1080, 32'h0);
        check("sll_op", {28'h0, Alu_op}, 32'h5);
        check("sll_shamt", {27'h0, Shamt}, 32'h2);

        // Unsupported opcode decodes as a NOP
        drive(32'hFC00_0000, 32'h0000_0077);
        check("ill_rw", {31'h0, Reg_write}, 32'h0);
        check("ill_jump", {31'h0, Jump}, 32'h0);
        drive(32'h2001_0005, 32'h0000_0077);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("trap_flag", {31'h0, Illegal}, 32'h1);
        check("trap_rw", {31'h0, Reg_write}, 32'h0);
        drive(32'h1020_0000, 32'h0);
        check("trap_r1", Rs_data, 32'h5);
        drive(32'h0C00_0010, 32'h0);
        check("trap_jump", {31'h0, Jump}, 32'h0);
`else
        check("notrap_flag", {31'h0, Illegal}, 32'h0);
        check("notrap_rw", {31'h0, Reg_write}, 32'h1);
        drive(32'h1020_0000, 32'h0);
        check("notrap_r1", Rs_data, 32'h0000_0077);
        drive(32'h0C00_0010, 32'h0);
        check("notrap_jump", {31'h0, Jump}, 32'h1);
`endif

        // Asynchronous reset in mid-cycle
        drive(32'h13A0_0000, 32'h0);
        #2;
        Reset = 1'b0;
        #1;
        check("arst_illegal", {31'h0, Illegal}, 32'h0);
        check("arst_reg31", reg31, 32'h0);
        check("arst_sp", Rs_data, c_reset_sp);
        check("arst_beq", {31'h0, Branch_eq}, 32'h1);
        Reset = 1'b1;
        drive(32'h1020_0000, 32'h0);
        check("arst_r1", Rs_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_regfile.md
# decode_regfile

Instruction-decode and register-file stage of the single-cycle CPU, directly downstream of `Fetch_Instruction`. It consumes `Inst` and the link address `w_reg31` from fetch, and decodes MIPS-subset control signals. It holds the 32×32 general-purpose register file and returns `Jump`/`Branch_eq`/`Branch_ne`/`reg31` to fetch. Reads are combinational; write-back commits on the clock edge.

## Interface
Parameters:
- `RESET_SP`, default 32'h0000_0000: reset value of register 29; all other registers reset to 0.

Ports:
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Inst`  in  32  current instruction from fetch.
- `Link_addr`  in  32  PC+4 from fetch (`w_reg31`); this is the `jal` write data.
- `Wb_data`  in  32  ALU/memory write-back data, valid within the same cycle.
- `Rs_data`, `Rt_data`  out  32  combinational reads of `Inst[25:21]` and `Inst[20:16]`.
- `Imm_ext`  out  32  extended `Inst[15:0]`.
- `Shamt`  out  5  `Inst[10:6]`.
- `Alu_op`  out  4  ALU operation code.
- `Alu_src`, `Mem_read`, `Mem_write`, `Mem_to_reg`, `Reg_write`  out  1  datapath controls.
- `Jump`, `Jump_reg`, `Branch_eq`, `Branch_ne`  out  1  next-PC controls to fetch.
- `reg31`  out  32  current contents of register 31, used for `jr $ra` in fetch.
- `Illegal`  out  1  sticky illegal-instruction flag. Present only with the macro; otherwise tied 0.

## Operation
- Opcodes supported: R-type 0x00, `j` 0x02, `jal` 0x03, `beq` 0x04, `bne` 0x05, `addi` 0x08, `slti` 0x0A, `andi` 0x0C, `ori` 0x0D, `lui` 0x0F, `lw` 0x23, `sw` 0x2B.
- R-type funct codes: `add` 0x20, `sub` 0x22, `and` 0x24, `or` 0x25, `slt` 0x2A, `sll` 0x00, `srl` 0x02, `jr` 0x08.
- `Alu_op` encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6, LUI=7.
  - `lw`, `sw`, `addi` → ADD.
  - `beq`, `bne` → SUB.
- Destination register:
  - R-type writes `rd` (`Inst[15:11]`).
  - I-type writes `rt`.
  - `jal` writes 31.
- Write data: `Link_addr` for `jal`; `Wb_data` otherwise.
- `Reg_write` is 1 for:
  - R-type ALU ops, excluding `jr`.
  - `addi`, `slti`, `andi`, `ori`, `lui`, `lw`, `jal`.
- Writes to register 0 are discarded. Register 0 always reads 0.
- `Imm_ext`: zero-extended for `andi`/`ori`; sign-extended for all other opcodes.
- Unsupported opcode or funct decodes as a NOP: all control outputs 0, no write.
- `jr` asserts `Jump_reg` only.

## Timing
- Reset asserted (low):
  - All registers clear immediately, except register 29 = `RESET_SP`.
  - `reg31` = 0 and `Illegal` = 0.
  - Decode outputs remain combinational functions of `Inst`.
- Reset deasserted mid-cycle: no write takes effect until the next rising edge.
- Register write: committed on the rising edge when the effective `Reg_write` = 1. New value is visible on read ports and `reg31` after that edge.
- Same-cycle read of the register being written returns the old value; there is no bypass, to avoid a combinational loop through the ALU.
- `reg31` has zero-cycle latency from register 31 contents.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - An unsupported opcode/funct at a rising edge sets `Illegal`. It stays 1 until reset.
  - While `Illegal` = 1, all register writes are suppressed and `Jump`, `Jump_reg`, `Branch_eq`, `Branch_ne` are forced 0.
- Macro undefined:
  - Unsupported encodings are silent NOPs.
  - `Illegal` is a constant 0.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode and funct constants
  - the `Alu_op` enumeration
  - register index constants `REG_ZERO`=0, `REG_SP`=29, `REG_RA`=31
- One sub-module, `reg_file_32x32`: two async read ports, one synchronous write port, async active-low clear, register-0 suppression.

## Test plan
- Reset low, then high → every read returns 0 except register 29 = `RESET_SP`; `reg31` = 0.
- `Inst`=0x20010005 (`addi $1,$0,5`) with `Wb_data`=5, one edge → `Reg_write`=1, `Alu_src`=1, `Alu_op`=ADD; `Rs_data` reads 5 once `Inst` selects rs=1.
- `Inst`=0x20000007 (`addi $0,$0,7`), one edge → register 0 still reads 0.
- `Inst`=0x0C000010 (`jal`) with `Link_addr`=0x00000008, one edge → `Jump`=1; `reg31`=0x00000008 after the edge, not before.
- `Inst`=0x1022FFFC (`beq $1,$2,-4`) → `Branch_eq`=1, `Alu_op`=SUB, `Imm_ext`=0xFFFFFFFC, `Reg_write`=0. `Inst`=0x3422FFFC (`ori`) → `Imm_ext`=0x0000FFFC.
- With `DECODE_ILLEGAL_TRAP_EN`, `Inst`=0xFC000000, one edge → `Illegal`=1. A following `addi $1,$0,5` does not write. Reset low → `Illegal`=0 immediately.
